writeback_arbiter: RTL and testbench

- Shares one 32-bit register-file writeback port among NUM_UNITS execution units: ALU, branch, load/store, mul, div, and similar.
- Each unit presents done/id/rd and holds it until acknowledged.
- The arbiter registers the winning result into a single output stage with a downstream ready handshake.
- Policy:
  - PRIORITY_UNIT, normally the single-cycle ALU, wins by default.
  - Other units are served round-robin.
  - A per-unit starvation counter guarantees forward progress.

---
 rtl/cva5_types.sv | 21 ++
 rtl/writeback_arbiter_if.sv | 32 +++
 rtl/rr_picker.sv | 39 +++
 rtl/writeback_arbiter.sv | 140 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cva5_types.sv
// Shared types for the writeback arbiter slice.
// Holds the unit-index width helper and the per-unit request record.
package cva5_types;

  localparam int WB_NUM_UNITS = 4;
  localparam int WB_ID_W      = 3;

  // Index width of a unit select; a lone unit still needs one bit.
  function automatic int wb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WB_UNIT_IDX_W = wb_idx_w(WB_NUM_UNITS);

  typedef struct packed {
    logic               done;
    logic [WB_ID_W-1:0] id;
    logic [31:0]        rd;
  } wb_arb_req_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Unit request/ack bundle plus the registered writeback port.
// master: arbiter side; slave: units and downstream consumer.
interface writeback_arbiter_if
  import cva5_types::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int ID_W      = 3
) ();

  localparam int IW = wb_idx_w(NUM_UNITS);

  logic [NUM_UNITS-1:0]           unit_done;
  logic [NUM_UNITS-1:0][ID_W-1:0] unit_id;
  logic [NUM_UNITS-1:0][31:0]     unit_rd;
  logic [NUM_UNITS-1:0]           unit_ack;
  logic                           wb_valid;
  logic [ID_W-1:0]                wb_id;
  logic [31:0]                    wb_rd;
  logic [IW-1:0]                  wb_unit;
  logic                           wb_ready;

  modport master (
    input  unit_done, unit_id, unit_rd, wb_ready,
    output unit_ack, wb_valid, wb_id, wb_rd, wb_unit
  );

  modport slave (
    output unit_done, unit_id, unit_rd, wb_ready,
    input  unit_ack, wb_valid, wb_id, wb_rd, wb_unit
  );

endinterface

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Ports: req, ptr in; one-hot gnt, encoded idx, any out.
module rr_picker
  import cva5_types::*;
#(
  parameter int NUM_UNITS = 4
) (
  input  logic [NUM_UNITS-1:0]           req,
  input  logic [wb_idx_w(NUM_UNITS)-1:0] ptr,
  output logic [NUM_UNITS-1:0]           gnt,
  output logic [wb_idx_w(NUM_UNITS)-1:0] idx,
  output logic                           any
);

  localparam int IW = wb_idx_w(NUM_UNITS);

  logic [2*NUM_UNITS-1:0] rot;
  int                     off;
  int                     sel;

  always_comb begin
    // Doubling the vector turns the wrap into a plain shift.
    rot = {req, req} >> ptr;
    off = 0;
    any = 1'b0;
    for (int o = 0; o < NUM_UNITS; o++) begin
      if (!any && rot[o]) begin
        any = 1'b1;
        off = o;
      end
    end
    sel = int'(ptr) + off;
    if (sel >= NUM_UNITS) sel = sel - NUM_UNITS;
    idx = IW'(sel);
    gnt = '0;
    if (any) gnt = NUM_UNITS'(1) << idx;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Shares one writeback port among execution units: priority unit,
// round-robin for the rest, starvation override; 1-cycle output stage.
module writeback_arbiter
  import cva5_types::*;
#(
  parameter int NUM_UNITS     = 4,
  parameter int ID_W          = 3,
  parameter int PRIORITY_UNIT = 0,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  writeback_arbiter_if.master bus
);

  localparam int IW = wb_idx_w(NUM_UNITS);
  localparam logic [NUM_UNITS-1:0] NP_MASK =
    ~(NUM_UNITS'(1) << PRIORITY_UNIT);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic                       wb_valid_q, wb_valid_d;
  logic [ID_W-1:0]            wb_id_q, wb_id_d;
  logic [31:0]                wb_rd_q, wb_rd_d;
  logic [IW-1:0]              wb_unit_q, wb_unit_d;
  logic [IW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [NUM_UNITS-1:0][3:0]  cnt_q, cnt_d;

  logic                 load_en;
  logic [NUM_UNITS-1:0] req_np;
  logic [NUM_UNITS-1:0] starved;
  logic [NUM_UNITS-1:0] pick_req;
  logic [NUM_UNITS-1:0] pk_gnt;
  logic [IW-1:0]        pk_idx;
  logic                 pk_any;
  logic [NUM_UNITS-1:0] gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_any;
  int                   nxt;

  always_comb begin
    load_en = ~wb_valid_q | bus.wb_ready;
    req_np  = bus.unit_done & NP_MASK;
    for (int i = 0; i < NUM_UNITS; i++) begin
      starved[i] = req_np[i] && (cnt_q[i] == LIMIT);
    end
    // One picker serves both the starved and the plain rr pass.
    pick_req = (|starved) ? starved : req_np;
  end

  rr_picker #(
    .NUM_UNITS (NUM_UNITS)
  ) u_pick (
    .req (pick_req),
    .ptr (rr_ptr_q),
    .gnt (pk_gnt),
    .idx (pk_idx),
    .any (pk_any)
  );

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (rst_n && load_en) begin
      if (|starved) begin
        gnt     = pk_gnt;
        gnt_idx = pk_idx;
        gnt_any = 1'b1;
      end else if (bus.unit_done[PRIORITY_UNIT]) begin
        gnt[PRIORITY_UNIT] = 1'b1;
        gnt_idx            = IW'(PRIORITY_UNIT);
        gnt_any            = 1'b1;
      end else if (pk_any) begin
        gnt     = pk_gnt;
        gnt_idx = pk_idx;
        gnt_any = 1'b1;
      end
    end
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_id_d    = wb_id_q;
    wb_rd_d    = wb_rd_q;
    wb_unit_d  = wb_unit_q;
    if (load_en) begin
      wb_valid_d = gnt_any;
      if (gnt_any) begin
        wb_id_d   = bus.unit_id[gnt_idx];
        wb_rd_d   = bus.unit_rd[gnt_idx];
        wb_unit_d = gnt_idx;
      end
    end

    rr_ptr_d = rr_ptr_q;
    nxt      = 0;
    if (gnt_any && gnt_idx != IW'(PRIORITY_UNIT)) begin
      nxt = int'(gnt_idx) + 1;
      if (nxt >= NUM_UNITS) nxt = 0;
      if (nxt == PRIORITY_UNIT) nxt = nxt + 1;
      if (nxt >= NUM_UNITS) nxt = 0;
      rr_ptr_d = IW'(nxt);
    end

    for (int i = 0; i < NUM_UNITS; i++) begin
      if (i == PRIORITY_UNIT || !bus.unit_done[i] || gnt[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != LIMIT) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_id_q    <= '0;
      wb_rd_q    <= '0;
      wb_unit_q  <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_id_q    <= wb_id_d;
      wb_rd_q    <= wb_rd_d;
      wb_unit_q  <= wb_unit_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.unit_ack = gnt;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_id    = wb_id_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_unit  = wb_unit_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed table, corner sequences,
// a single-unit instance and random traffic against a reference model.
module tb_writeback_arbiter;
  import cva5_types::*;

  localparam int N   = 4;
  localparam int PRI = 0;
  localparam int LIM = 3;

  logic clk;
  logic rst_n;

  writeback_arbiter_if #(.NUM_UNITS(N), .ID_W(3)) bus4 ();
  writeback_arbiter_if #(.NUM_UNITS(1), .ID_W(3)) bus1 ();

  writeback_arbiter #(
    .NUM_UNITS(N), .ID_W(3), .PRIORITY_UNIT(PRI), .STARVE_LIMIT(LIM)
  ) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.master)
  );

  writeback_arbiter #(
    .NUM_UNITS(1), .ID_W(3), .PRIORITY_UNIT(0), .STARVE_LIMIT(LIM)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] done;
    bit         ready;
    logic [3:0] ack;
    bit         valid;
    int         unit;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] rd_tab[4] = '{32'hDEADBEEF, 32'h11111111,
                             32'h22222222, 32'h33333333};
  wb_arb_req_t req[N];
  bit          rdy;

  logic        m_valid;
  logic [2:0]  m_id;
  logic [31:0] m_rd;
  int          m_unit;
  int          m_ptr;
  int          m_wait[N];

  task automatic drive4();
    for (int i = 0; i < N; i++) begin
      bus4.unit_done[i] = req[i].done;
      bus4.unit_id[i]   = req[i].id;
      bus4.unit_rd[i]   = req[i].rd;
    end
    bus4.wb_ready = rdy;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) req[i] = '0;
    rdy = 1'b1;
    drive4();
  endtask

  task automatic set_fixed(input logic [3:0] done);
    for (int i = 0; i < N; i++) begin
      req[i].done = done[i];
      req[i].id   = 3'(i + 1);
      req[i].rd   = rd_tab[i];
    end
  endtask

  // Leaves the caller at posedge+1 with reset just released.
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Reference arbitration: who is served this cycle, -1 if nobody.
  function automatic int ref_grant();
    int j;
    if (m_valid && !rdy) return -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (j != PRI && req[j].done && m_wait[j] >= LIM) return j;
    end
    if (req[PRI].done) return PRI;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (j != PRI && req[j].done) return j;
    end
    return -1;
  endfunction

  initial begin
    int g;
    logic [3:0] exp_ack;

    rst_n = 1'b0;
    bus1.unit_done = '0;
    bus1.unit_id   = '0;
    bus1.unit_rd   = '0;
    bus1.wb_ready  = 1'b1;
    clear_reqs();

    // rr fairness, priority, starvation, backpressure with hold
    vt.push_back('{1, 4'b1110, 1, 4'b0010, 0, 0});
    vt.push_back('{0, 4'b1110, 1, 4'b0100, 1, 1});
    vt.push_back('{0, 4'b1110, 1, 4'b1000, 1, 2});
    vt.push_back('{0, 4'b1110, 1, 4'b0010, 1, 3});
    vt.push_back('{0, 4'b1110, 1, 4'b0100, 1, 1});
    vt.push_back('{0, 4'b1110, 1, 4'b1000, 1, 2});
    vt.push_back('{1, 4'b1001, 1, 4'b0001, 0, 0});
    vt.push_back('{0, 4'b1001, 1, 4'b0001, 1, 0});
    vt.push_back('{0, 4'b1001, 1, 4'b0001, 1, 0});
    vt.push_back('{0, 4'b1001, 1, 4'b1000, 1, 0});
    vt.push_back('{0, 4'b0001, 1, 4'b0001, 1, 3});
    vt.push_back('{0, 4'b0101, 1, 4'b0001, 1, 0});
    vt.push_back('{0, 4'b0101, 0, 4'b0000, 1, 0});
    vt.push_back('{0, 4'b0101, 0, 4'b0000, 1, 0});
    vt.push_back('{0, 4'b0101, 0, 4'b0000, 1, 0});
    vt.push_back('{0, 4'b0101, 0, 4'b0000, 1, 0});
    vt.push_back('{0, 4'b0101, 1, 4'b0100, 1, 0});
    vt.push_back('{0, 4'b0001, 1, 4'b0001, 1, 2});
    vt.push_back('{0, 4'b0000, 1, 4'b0000, 1, 0});
    vt.push_back('{0, 4'b0000, 1, 4'b0000, 0, 0});

    foreach (vt[r]) begin
      if (vt[r].rst) do_reset();
      else begin
        @(posedge clk);
        #1;
      end
      set_fixed(vt[r].done);
      rdy = vt[r].ready;
      drive4();
      @(negedge clk);
      chk($sformatf("tbl%0d_ack", r), 32'(bus4.unit_ack), 32'(vt[r].ack));
      chk($sformatf("tbl%0d_valid", r), 32'(bus4.wb_valid),
          32'(vt[r].valid));
      if (vt[r].valid) begin
        chk($sformatf("tbl%0d_unit", r), 32'(bus4.wb_unit),
            32'(vt[r].unit));
        chk($sformatf("tbl%0d_id", r), 32'(bus4.wb_id),
            32'(vt[r].unit + 1));
        chk($sformatf("tbl%0d_rd", r), bus4.wb_rd, rd_tab[vt[r].unit]);
      end
    end

    // Reset asserted mid-stream with a result in the output stage
    do_reset();
    set_fixed(4'b0010);
    rdy = 1'b0;
    drive4();
    @(negedge clk);
    chk("rst_pre_ack", 32'(bus4.unit_ack), 32'h2);
    @(posedge clk);
    #1;
    drive4();
    @(negedge clk);
    chk("rst_pre_valid", 32'(bus4.wb_valid), 32'h1);
    @(posedge clk);
    #2;
    set_fixed(4'b1111);
    rdy = 1'b1;
    drive4();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus4.wb_valid), 32'h0);
    chk("rst_ack", 32'(bus4.unit_ack), 32'h0);
    chk("rst_rd", bus4.wb_rd, 32'h0);
    chk("rst_unit", 32'(bus4.wb_unit), 32'h0);
    chk("rst_id", 32'(bus4.wb_id), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_fixed(4'b0110);
    drive4();
    @(negedge clk);
    chk("rst_first_ack", 32'(bus4.unit_ack), 32'h2);

    // Single-unit instance: ack every cycle, data one cycle later
    clear_reqs();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      bus1.unit_done = (k < 3) ? 1'b1 : 1'b0;
      bus1.unit_rd[0] = 32'(k + 1);
      bus1.unit_id[0] = 3'(k);
      bus1.wb_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("n1_ack%0d", k), 32'(bus1.unit_ack),
          (k < 3) ? 32'h1 : 32'h0);
      if (k >= 1 && k <= 3) begin
        chk($sformatf("n1_valid%0d", k), 32'(bus1.wb_valid), 32'h1);
        chk($sformatf("n1_rd%0d", k), bus1.wb_rd, 32'(k));
      end
      if (k == 4) chk("n1_valid_end", 32'(bus1.wb_valid), 32'h0);
    end

    // Random traffic against the reference model
    do_reset();
    m_valid = 1'b0;
    m_id    = '0;
    m_rd    = '0;
    m_unit  = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    for (int c = 0; c < 800; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      drive4();
      @(negedge clk);
      g = ref_grant();
      exp_ack = (g < 0) ? 4'b0 : (4'b1 << g);
      chk("rnd_ack", 32'(bus4.unit_ack), 32'(exp_ack));
      chk("rnd_valid", 32'(bus4.wb_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rnd_unit", 32'(bus4.wb_unit), 32'(m_unit));
        chk("rnd_id", 32'(bus4.wb_id), 32'(m_id));
        chk("rnd_rd", bus4.wb_rd, m_rd);
      end
      if (!m_valid || rdy) begin
        m_valid = (g >= 0);
        if (g >= 0) begin
          m_id   = req[g].id;
          m_rd   = req[g].rd;
          m_unit = g;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (i != PRI && req[i].done && g != i)
          m_wait[i] = (m_wait[i] < LIM) ? m_wait[i] + 1 : LIM;
        else
          m_wait[i] = 0;
      end
      if (g >= 0 && g != PRI) begin
        m_ptr = (g + 1) % N;
        if (m_ptr == PRI) m_ptr = (m_ptr + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if ((req[i].done && g == i && $urandom_range(1, 0) == 1) ||
            (!req[i].done && $urandom_range(9, 0) < 4)) begin
          req[i].done = 1'b1;
          req[i].id   = 3'($urandom);
          req[i].rd   = $urandom;
        end else if (req[i].done && g == i) begin
          req[i].done = 1'b0;
        end
      end
      rdy = ($urandom_range(3, 0) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
